// File: rtl/hazard_pkg.sv
//------------------------------------------------------------------------------
// hazard_pkg : shared state encoding and constants for the hazard sequencer
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
//------------------------------------------------------------------------------
// hazard_perf_cnt : bank of three saturating 32-bit event counters
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_evt_i,
  input  logic        flush_evt_i,
  input  logic        frz_evt_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] wait_cnt_o
);

  logic [2:0]  w_evt;
  logic [31:0] w_cnt [3];

  assign w_evt = {frz_evt_i, flush_evt_i, stall_evt_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [31:0] r_val;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_val <= '0;
      end else if (w_evt[gi] && (r_val != 32'hFFFF_FFFF)) begin
        r_val <= r_val + 32'd1;
      end
    end

    assign w_cnt[gi] = r_val;
  end

  assign stall_cnt_o = w_cnt[0];
  assign flush_cnt_o = w_cnt[1];
  assign wait_cnt_o  = w_cnt[2];

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// hazard_ctrl : pipeline register sequencer (load-use, branch flush, memory
//               wait freeze, timeout trap). HAZARD_PERF_EN adds event counters.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

import hazard_pkg::*;

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ifid_rs1_i,
  input  logic [4:0]  ifid_rs2_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rd_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        idex_hold_o,
  output logic        exmem_hold_o,
  output logic        memwb_bubble_o,
  output logic        err_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] wait_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_wait_cnt, w_next_cnt, w_cnt_inc;
  logic             w_freeze, w_load_use;

  assign w_load_use = idex_memread_i && (idex_rd_i != REG_ZERO) &&
                      ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
  assign w_freeze   = (dmem_req_i && !dmem_ready_i) || (r_state == ERROR);
  assign w_cnt_inc  = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + c_one;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_cnt;
    end
  end

  // The counter holds the number of frozen cycles seen so far; the trap fires
  // on the edge where that number reaches MEM_TIMEOUT.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          w_next_cnt   = c_one;
          w_next_state = (c_one >= c_timeout) ? ERROR : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!dmem_req_i || dmem_ready_i) begin
          w_next_state = RUN;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = w_cnt_inc;
          if (w_cnt_inc >= c_timeout) begin
            w_next_state = ERROR;
          end
        end
      end
      ERROR: begin
        w_next_state = ERROR;
      end
      default: begin
        w_next_state = RUN;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    pc_write_o     = 1'b1;
    ifid_stall_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    idex_hold_o    = 1'b0;
    exmem_hold_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_bubble_o  = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (w_freeze) begin
      pc_write_o     = 1'b0;
      ifid_stall_o   = 1'b1;
      idex_hold_o    = 1'b1;
      exmem_hold_o   = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (w_load_use) begin
      // Branch is ignored here; it re-resolves once the load is forwarded.
      pc_write_o    = 1'b0;
      ifid_stall_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  assign err_o = (r_state == ERROR) && !rst_i;

`ifdef HAZARD_PERF_EN
  logic w_stall_evt, w_flush_evt, w_frz_evt;

  assign w_stall_evt = !rst_i && !w_freeze && w_load_use;
  assign w_flush_evt = !rst_i && !w_freeze && !w_load_use && branch_taken_i;
  assign w_frz_evt   = !rst_i && w_freeze;

  hazard_perf_cnt u_perf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_evt_i (w_stall_evt),
    .flush_evt_i (w_flush_evt),
    .frz_evt_i   (w_frz_evt),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o),
    .wait_cnt_o  (wait_cnt_o)
  );
`else
  // Event counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_hazard_ctrl : vector table + scoreboard bench for hazard_ctrl
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;

  // Output packing: {pc_write, ifid_stall, ifid_flush, idex_bubble,
  //                  idex_hold, exmem_hold, memwb_bubble, err}
  localparam logic [7:0] E_RST  = 8'b0011_0010;
  localparam logic [7:0] E_NORM = 8'b1000_0000;
  localparam logic [7:0] E_LU   = 8'b0101_0000;
  localparam logic [7:0] E_BR   = 8'b1010_0000;
  localparam logic [7:0] E_FRZ  = 8'b0100_1110;
  localparam logic [7:0] E_ERR  = 8'b0100_1111;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       memread;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       idex_memread, branch_taken, dmem_req, dmem_ready;
  logic       pc_write, ifid_stall, ifid_flush, idex_bubble;
  logic       idex_hold, exmem_hold, memwb_bubble, err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ifid_rs1_i     (ifid_rs1),
    .ifid_rs2_i     (ifid_rs2),
    .idex_memread_i (idex_memread),
    .idex_rd_i      (idex_rd),
    .branch_taken_i (branch_taken),
    .dmem_req_i     (dmem_req),
    .dmem_ready_i   (dmem_ready),
    .pc_write_o     (pc_write),
    .ifid_stall_o   (ifid_stall),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .idex_hold_o    (idex_hold),
    .exmem_hold_o   (exmem_hold),
    .memwb_bubble_o (memwb_bubble),
    .err_o          (err)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt),
    .wait_cnt_o     (wait_cnt)
`endif
  );

  function automatic vec_t mk(logic r, logic [4:0] s1, logic [4:0] s2, logic mr,
                              logic [4:0] d, logic b, logic q, logic y, logic [7:0] e);
    vec_t v;
    v.rst = r; v.rs1 = s1; v.rs2 = s2; v.memread = mr; v.rd = d;
    v.br = b; v.req = q; v.rdy = y; v.exp = e;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {pc_write, ifid_stall, ifid_flush, idex_bubble,
            idex_hold, exmem_hold, memwb_bubble, err};
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; ifid_rs1 = v.rs1; ifid_rs2 = v.rs2; idex_memread = v.memread;
    idex_rd = v.rd; branch_taken = v.br; dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    sb_t sb;
    int  n;
    rst = 1'b1; ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
    idex_memread = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

    //              rst rs1 rs2 mr rd  br req rdy exp
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, E_RST));   // 0 reset
    vecs.push_back(mk(1, 5, 5, 1, 5, 1, 1, 0, E_RST));   // 1 reset dominates
    vecs.push_back(mk(0, 1, 2, 0, 3, 0, 0, 0, E_NORM));  // 2 idle
    vecs.push_back(mk(0, 1, 5, 1, 5, 0, 0, 0, E_LU));    // 3 load-use on rs2
    vecs.push_back(mk(0, 1, 5, 0, 5, 0, 0, 0, E_NORM));  // 4 one bubble only
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, E_NORM));  // 5 rd=x0 never hazards
    vecs.push_back(mk(0, 7, 2, 1, 7, 0, 0, 0, E_LU));    // 6 load-use on rs1
    vecs.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0, E_BR));    // 7 branch flush
    vecs.push_back(mk(0, 3, 2, 1, 3, 1, 0, 0, E_LU));    // 8 load-use beats branch
    vecs.push_back(mk(0, 4, 5, 1, 3, 1, 0, 0, E_BR));    // 9 load, no match
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 1, E_NORM));  // 10 zero-wait access
    vecs.push_back(mk(0, 3, 2, 1, 3, 1, 1, 0, E_FRZ));   // 11 freeze beats all
    vecs.push_back(mk(0, 3, 2, 1, 3, 1, 1, 0, E_FRZ));   // 12
    vecs.push_back(mk(0, 3, 2, 1, 3, 1, 1, 0, E_FRZ));   // 13
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 1, E_NORM));  // 14 ready: advance
    vecs.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0, E_BR));    // 15 back in RUN
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 16 wait
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, E_NORM));  // 17 req dropped
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 18 wait again
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 1, E_NORM));  // 19 complete
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 20 timeout run 1
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 21
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 22
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 23 fourth wait
    vecs.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0, E_ERR));   // 24 trapped
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 1, E_ERR));   // 25 sticky
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, E_RST));   // 26 reset clears
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, E_NORM));  // 27
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 28 wait
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 29 wait
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 1, 0, E_RST));   // 30 reset mid-wait
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 31 counter restarts
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 32
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 33
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));   // 34
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, E_ERR));   // 35
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, E_RST));   // 36
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, E_NORM));  // 37

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sbq.push_back('{i, vecs[i].exp});
      #1;
      sb = sbq.pop_front();
      checks++;
      if (outs() !== sb.exp) begin
        failures++;
        $display("FAIL vec%0d outputs got=%b want=%b", sb.idx, outs(), sb.exp);
      end
    end

    // Timeout measured live: frozen cycles before err_o rises, bounded budget.
    @(negedge clk);
    drive(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (err) break;
      n++;
      @(negedge clk);
    end
    check_val("timeout_cycles", n, TIMEOUT);
    check_val("err_raised", int'(err), 1);
    @(negedge clk);
    drive(mk(0, 1, 2, 0, 0, 0, 0, 0, E_ERR));
    @(negedge clk); #1;
    check_val("err_sticky", int'(err), 1);
    check_val("pc_write_in_error", int'(pc_write), 0);

    @(negedge clk);
    drive(mk(1, 1, 2, 0, 0, 0, 1, 0, E_RST));
    @(negedge clk);
    drive(mk(0, 1, 2, 0, 0, 0, 0, 0, E_NORM));
    #1;
    check_val("err_after_reset", int'(err), 0);
`ifdef HAZARD_PERF_EN
    check_val("stall_cnt_reset", int'(stall_cnt), 0);
    check_val("flush_cnt_reset", int'(flush_cnt), 0);
    check_val("wait_cnt_reset", int'(wait_cnt), 0);
    @(negedge clk); drive(mk(0, 5, 2, 1, 5, 1, 0, 0, E_LU));
    @(negedge clk); drive(mk(0, 1, 2, 0, 0, 1, 0, 0, E_BR));
    @(negedge clk); drive(mk(0, 1, 2, 0, 0, 1, 1, 0, E_FRZ));
    @(negedge clk); drive(mk(0, 1, 2, 0, 0, 0, 1, 0, E_FRZ));
    @(negedge clk); drive(mk(0, 1, 2, 0, 0, 0, 1, 1, E_NORM));
    @(negedge clk); #1;
    check_val("stall_cnt", int'(stall_cnt), 1);
    check_val("flush_cnt", int'(flush_cnt), 1);
    check_val("wait_cnt", int'(wait_cnt), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
